// File: rtl/pcpi_issue.sv
// pcpi_issue: issues one coprocessor instruction at a time onto a PCPI-style
// responder bus and holds a completion record until the core acknowledges it.
//
// Optional feature: define PCPI_ISSUE_TIMEOUT_EN to flag an instruction as
// illegal when the responder neither answers nor asserts pcpi_wait within
// TIMEOUT_CYCLES cycles. Without the macro the issuer waits for pcpi_ready
// indefinitely and done_illinsn is tied low.
//
// Ports:
//   clk, reset                    clock, asynchronous active-high reset
//   issue_valid/issue_ready       core offer handshake (ready only in IDLE)
//   issue_insn/rs1/rs2            offered instruction word and operands
//   pcpi_valid                    instruction presented to the responder
//   pcpi_insn/rs1/rs2             registered instruction word and operands
//   pcpi_wr/rd/wait/ready         responder result and stall indication
//   done_valid                    completion record held for the core
//   done_wr/rd/illinsn            completion record
//   done_ack                      core consumes the completion record
module pcpi_issue #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        issue_valid,
  output logic        issue_ready,
  input  logic [31:0] issue_insn,
  input  logic [31:0] issue_rs1,
  input  logic [31:0] issue_rs2,
  output logic        pcpi_valid,
  output logic [31:0] pcpi_insn,
  output logic [31:0] pcpi_rs1,
  output logic [31:0] pcpi_rs2,
  input  logic        pcpi_wr,
  input  logic [31:0] pcpi_rd,
  input  logic        pcpi_wait,
  input  logic        pcpi_ready,
  output logic        done_valid,
  output logic        done_wr,
  output logic [31:0] done_rd,
  output logic        done_illinsn,
  input  logic        done_ack
);

  generate
    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 31) begin : g_bad_timeout
      $error("pcpi_issue: TIMEOUT_CYCLES must be in 2..31");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

  state_t state;

  // Handshake outputs are pure decodes of the state register, so they change
  // only on a clock edge or immediately on reset.
  assign issue_ready = (state == IDLE);
  assign pcpi_valid  = (state == ISSUE);
  assign done_valid  = (state == DONE);

`ifdef PCPI_ISSUE_TIMEOUT_EN
  localparam logic [4:0] TMO_LAST = 5'(TIMEOUT_CYCLES - 1);

  logic [4:0] tmo_cnt;
  logic       wait_seen;
  logic       ill_q;
  logic       wait_now;

  // A wait in the current cycle already suppresses this cycle's count.
  assign wait_now     = wait_seen | pcpi_wait;
  assign done_illinsn = ill_q;
`else
  logic unused_wait;

  assign unused_wait  = pcpi_wait;
  assign done_illinsn = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      pcpi_insn <= '0;
      pcpi_rs1  <= '0;
      pcpi_rs2  <= '0;
      done_wr   <= 1'b0;
      done_rd   <= '0;
`ifdef PCPI_ISSUE_TIMEOUT_EN
      tmo_cnt   <= '0;
      wait_seen <= 1'b0;
      ill_q     <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (issue_valid) begin
            pcpi_insn <= issue_insn;
            pcpi_rs1  <= issue_rs1;
            pcpi_rs2  <= issue_rs2;
`ifdef PCPI_ISSUE_TIMEOUT_EN
            tmo_cnt   <= '0;
            wait_seen <= 1'b0;
`endif
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          // A response always takes priority over both wait and timeout.
          if (pcpi_ready) begin
            done_wr <= pcpi_wr;
            done_rd <= pcpi_wr ? pcpi_rd : '0;
`ifdef PCPI_ISSUE_TIMEOUT_EN
            ill_q   <= 1'b0;
`endif
            state   <= DONE;
          end
`ifdef PCPI_ISSUE_TIMEOUT_EN
          else begin
            wait_seen <= wait_now;
            if (!wait_now) begin
              if (tmo_cnt == TMO_LAST) begin
                done_wr <= 1'b0;
                done_rd <= '0;
                ill_q   <= 1'b1;
                state   <= DONE;
              end else begin
                tmo_cnt <= tmo_cnt + 5'd1;
              end
            end
          end
`endif
        end
        DONE: begin
          if (done_ack) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pcpi_issue.sv
// Self-checking bench for pcpi_issue. Inputs are driven and outputs sampled
// on the falling clock edge. The expected outcome of each transaction is
// derived from the responder schedule (cycle of first ready, cycle wait is
// raised) by plain arithmetic in ref_outcome.
module tb_pcpi_issue;

  localparam int unsigned TO = 16;
`ifdef PCPI_ISSUE_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        issue_valid;
  logic        issue_ready;
  logic [31:0] issue_insn;
  logic [31:0] issue_rs1;
  logic [31:0] issue_rs2;
  logic        pcpi_valid;
  logic [31:0] pcpi_insn;
  logic [31:0] pcpi_rs1;
  logic [31:0] pcpi_rs2;
  logic        pcpi_wr;
  logic [31:0] pcpi_rd;
  logic        pcpi_wait;
  logic        pcpi_ready;
  logic        done_valid;
  logic        done_wr;
  logic [31:0] done_rd;
  logic        done_illinsn;
  logic        done_ack;

  int checks = 0;
  int errors = 0;

  pcpi_issue #(.TIMEOUT_CYCLES(TO)) dut (
    .clk          (clk),
    .reset        (reset),
    .issue_valid  (issue_valid),
    .issue_ready  (issue_ready),
    .issue_insn   (issue_insn),
    .issue_rs1    (issue_rs1),
    .issue_rs2    (issue_rs2),
    .pcpi_valid   (pcpi_valid),
    .pcpi_insn    (pcpi_insn),
    .pcpi_rs1     (pcpi_rs1),
    .pcpi_rs2     (pcpi_rs2),
    .pcpi_wr      (pcpi_wr),
    .pcpi_rd      (pcpi_rd),
    .pcpi_wait    (pcpi_wait),
    .pcpi_ready   (pcpi_ready),
    .done_valid   (done_valid),
    .done_wr      (done_wr),
    .done_rd      (done_rd),
    .done_illinsn (done_illinsn),
    .done_ack     (done_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // ready_at/wait_at are 1-based ISSUE cycle numbers, 0 = never.
  // len is the number of cycles pcpi_valid stays high, 0 = never completes.
  task automatic ref_outcome(input int ready_at, input int wait_at,
                             output int len, output bit ill);
    bit can_time_out;
    can_time_out = TO_EN && (wait_at == 0 || wait_at > int'(TO));
    ill = 1'b0;
    len = 0;
    if (ready_at != 0 && (!can_time_out || ready_at <= int'(TO))) begin
      len = ready_at;
    end else if (can_time_out) begin
      len = int'(TO);
      ill = 1'b1;
    end
  endtask

  task automatic quiet_inputs();
    issue_valid = 1'b0;
    issue_insn  = '0;
    issue_rs1   = '0;
    issue_rs2   = '0;
    pcpi_wr     = 1'b0;
    pcpi_rd     = '0;
    pcpi_wait   = 1'b0;
    pcpi_ready  = 1'b0;
    done_ack    = 1'b0;
  endtask

  task automatic run_txn(input logic [31:0] insn, input logic [31:0] rs1,
                         input logic [31:0] rs2, input int ready_at,
                         input int wait_at, input logic wr,
                         input logic [31:0] rd, input int ack_delay);
    int          exp_len;
    bit          exp_ill;
    logic        exp_wr;
    logic [31:0] exp_rd;
    int          cyc;
    logic        rec_wr;
    logic [31:0] rec_rd;
    logic        rec_ill;
    ref_outcome(ready_at, wait_at, exp_len, exp_ill);
    exp_wr = exp_ill ? 1'b0 : wr;
    exp_rd = (exp_ill || !wr) ? 32'h0 : rd;

    @(negedge clk);
    check("idle_issue_ready", issue_ready, 32'd1);
    check("idle_pcpi_valid", pcpi_valid, 32'd0);
    issue_valid = 1'b1;
    issue_insn  = insn;
    issue_rs1   = rs1;
    issue_rs2   = rs2;

    cyc = 1;
    while (cyc <= 300) begin
      @(negedge clk);
      // Offer noise during ISSUE must be ignored.
      issue_valid = 1'($urandom_range(0, 1));
      issue_insn  = $urandom;
      issue_rs1   = $urandom;
      issue_rs2   = $urandom;
      if (!pcpi_valid) break;
      check("issue_ready_busy", issue_ready, 32'd0);
      check("pcpi_insn", pcpi_insn, insn);
      check("pcpi_rs1", pcpi_rs1, rs1);
      check("pcpi_rs2", pcpi_rs2, rs2);
      pcpi_ready = (cyc == ready_at);
      pcpi_wait  = (wait_at != 0 && cyc >= wait_at);
      pcpi_wr    = (cyc == ready_at) ? wr : 1'($urandom_range(0, 1));
      pcpi_rd    = (cyc == ready_at) ? rd : $urandom;
      done_ack   = 1'($urandom_range(0, 1));
      cyc++;
    end
    done_ack = 1'b0;
    check("valid_len", 32'(cyc - 1), 32'(exp_len));
    check("done_valid", done_valid, 32'd1);
    check("done_wr", done_wr, exp_wr);
    check("done_rd", done_rd, exp_rd);
    check("done_illinsn", done_illinsn, exp_ill);
    rec_wr  = exp_wr;
    rec_rd  = exp_rd;
    rec_ill = exp_ill;

    for (int k = 0; k < ack_delay; k++) begin
      pcpi_ready  = 1'($urandom_range(0, 1));
      pcpi_wait   = 1'($urandom_range(0, 1));
      pcpi_wr     = 1'($urandom_range(0, 1));
      pcpi_rd     = $urandom;
      issue_valid = 1'b1;
      @(negedge clk);
      check("hold_done_valid", done_valid, 32'd1);
      check("hold_issue_ready", issue_ready, 32'd0);
      check("hold_record", {done_rd[29:0], done_wr, done_illinsn},
            {rec_rd[29:0], rec_wr, rec_ill});
      check("hold_rd", done_rd, rec_rd);
    end

    // Offer stays up through the ack cycle; it must not be taken in DONE.
    issue_valid = 1'b1;
    pcpi_ready  = 1'b0;
    pcpi_wait   = 1'b0;
    done_ack    = 1'b1;
    @(negedge clk);
    check("ack_issue_ready", issue_ready, 32'd1);
    check("ack_done_valid", done_valid, 32'd0);
    check("ack_no_bypass", pcpi_valid, 32'd0);
    quiet_inputs();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_issue_ready"}, issue_ready, 32'd1);
    check({tag, "_pcpi_valid"}, pcpi_valid, 32'd0);
    check({tag, "_done_valid"}, done_valid, 32'd0);
    check({tag, "_done_wr"}, done_wr, 32'd0);
    check({tag, "_done_rd"}, done_rd, 32'd0);
    check({tag, "_done_illinsn"}, done_illinsn, 32'd0);
    check({tag, "_pcpi_insn"}, pcpi_insn, 32'd0);
    check({tag, "_pcpi_rs1"}, pcpi_rs1, 32'd0);
    check({tag, "_pcpi_rs2"}, pcpi_rs2, 32'd0);
  endtask

  // Accept an instruction, let it sit in ISSUE for n cycles with no
  // responder, then abort it with reset.
  task automatic abort_in_issue(input int n, input string tag);
    int high;
    @(negedge clk);
    issue_valid = 1'b1;
    issue_insn  = $urandom;
    issue_rs1   = $urandom;
    issue_rs2   = $urandom;
    high = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      issue_valid = 1'b0;
      if (pcpi_valid && !done_valid) high++;
    end
    check({tag, "_valid_cycles"}, 32'(high), 32'(n));
    reset = 1'b1;
    #1;
    check({tag, "_async_drop"}, pcpi_valid, 32'd0);
    check({tag, "_async_ready"}, issue_ready, 32'd1);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_reset_state(tag);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int ra, wa, ad;
    quiet_inputs();
    reset = 1'b1;
    #1;
    check("por_pcpi_valid", pcpi_valid, 32'd0);
    do_reset();
    check_reset_state("rst");

    // Basic multiply-style instruction, responder ready in 3rd cycle.
    run_txn(32'h02C58533, 32'd7, 32'd6, 3, 0, 1'b1, 32'd42, 0);
    // Responder stalls with wait from cycle 2, answers in cycle 40.
    run_txn($urandom, $urandom, $urandom, 40, 2, 1'b1, 32'hDEADBEEF, 1);
    // Ready coincides with the timeout cycle; ready wins, wr=0 masks rd.
    run_txn($urandom, $urandom, $urandom, 16, 0, 1'b0, 32'd5, 0);
    // Ready in cycle 15, just before the timeout cycle.
    run_txn($urandom, $urandom, $urandom, 15, 0, 1'b1, 32'h1234_5678, 0);
    // Wait raised exactly in the timeout cycle defeats the timeout.
    run_txn($urandom, $urandom, $urandom, 25, 16, 1'b1, 32'hCAFE_0001, 0);
    // Ready and wait in the same cycle.
    run_txn($urandom, $urandom, $urandom, 4, 4, 1'b1, 32'h0BAD_F00D, 0);
    // Long hold of the completion record with noise on every input.
    run_txn($urandom, $urandom, $urandom, 5, 0, 1'b1, 32'h5555_AAAA, 10);

    // No responder at all.
    if (TO_EN) begin
      run_txn($urandom, $urandom, $urandom, 0, 0, 1'b1, 32'hFFFF_FFFF, 2);
    end else begin
      abort_in_issue(120, "noresp");
    end

    // Reset asserted in the second ISSUE cycle.
    abort_in_issue(2, "rst_issue");

    for (int t = 0; t < 40; t++) begin
      if (TO_EN && $urandom_range(0, 5) == 0) ra = 0;
      else ra = int'($urandom_range(1, 30));
      wa = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 20));
      ad = int'($urandom_range(0, 4));
      run_txn($urandom, $urandom, $urandom, ra, wa, 1'($urandom_range(0, 1)),
              $urandom, ad);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pcpi_issue.md
PCPI_ISSUE -- requirements
Module: pcpi_issue

Interface
REQ-001 The module SHALL have parameter TIMEOUT_CYCLES, default 16, giving the number of pcpi_valid cycles without pcpi_wait before an instruction is declared illegal; legal range is 2..31.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The module SHALL have port issue_valid, input, 1 bit: the core offers an instruction for the coprocessor.
REQ-005 The module SHALL have port issue_ready, output, 1 bit: an offer is accepted this cycle.
REQ-006 The module SHALL have ports issue_insn, issue_rs1 and issue_rs2, each input, 32 bits: the offered instruction word and its operands.
REQ-007 The module SHALL have port pcpi_valid, output, 1 bit: an instruction is presented to the responder.
REQ-008 The module SHALL have ports pcpi_insn, pcpi_rs1 and pcpi_rs2, each output, 32 bits: the registered instruction word and operands.
REQ-009 The module SHALL have ports pcpi_wr (1 bit), pcpi_rd (32 bits), pcpi_wait (1 bit) and pcpi_ready (1 bit), all inputs: the responder's result.
REQ-010 The module SHALL have port done_valid, output, 1 bit: a completion record is held for the core.
REQ-011 The module SHALL have ports done_wr (1 bit), done_rd (32 bits) and done_illinsn (1 bit), all outputs: the completion record.
REQ-012 The module SHALL have port done_ack, input, 1 bit: the core consumes the completion record.

Function
REQ-013 The module SHALL implement a state machine with three states: IDLE, ISSUE and DONE.
REQ-014 In IDLE, issue_ready SHALL be 1; in every other state it SHALL be 0.
REQ-015 In IDLE with issue_valid=1, the module SHALL register insn/rs1/rs2 onto pcpi_*, clear the timeout counter and wait_seen, and enter ISSUE.
REQ-016 pcpi_valid SHALL be 1 exactly while in ISSUE, and pcpi_insn/rs1/rs2 SHALL remain stable throughout ISSUE.
REQ-017 In ISSUE, pcpi_ready=1 SHALL capture done_wr=pcpi_wr and done_rd=(pcpi_wr ? pcpi_rd : 0), set done_illinsn=0, and enter DONE.
REQ-018 Latency: if the offer is accepted in cycle T and pcpi_ready is first seen in cycle T+k (k≥1), pcpi_valid SHALL be 0 and done_valid SHALL be 1 in cycle T+k+1.
REQ-019 In ISSUE, pcpi_wait=1 in any cycle SHALL set sticky wait_seen, which disables the timeout for the rest of that instruction.
REQ-020 The timeout counter SHALL increment each ISSUE cycle in which pcpi_ready=0 and wait_seen=0 (including the current cycle's pcpi_wait).
REQ-021 When the counter equals TIMEOUT_CYCLES-1 and it would increment, the module SHALL enter DONE with done_illinsn=1, done_wr=0 and done_rd=0, so that pcpi_valid is high for exactly TIMEOUT_CYCLES cycles.
REQ-022 If pcpi_ready and the timeout condition occur in the same cycle, pcpi_ready SHALL win.
REQ-023 If pcpi_ready and pcpi_wait occur in the same cycle, pcpi_ready SHALL win.
REQ-024 pcpi_ready, pcpi_wait, pcpi_wr and pcpi_rd SHALL be ignored in IDLE and DONE.
REQ-025 In DONE, done_valid SHALL be 1 and the record SHALL be held stable until done_ack=1, which SHALL return the module to IDLE on the next cycle.
REQ-026 done_ack outside DONE SHALL be ignored.
REQ-027 A new offer SHALL be accepted no earlier than the cycle after the DONE-to-IDLE transition; there is no back-to-back bypass.

Reset
REQ-028 While reset=1, the module SHALL immediately force IDLE, with pcpi_valid=0, issue_ready=1 after state clears, done_valid=0, done_wr=0, done_rd=0, done_illinsn=0, pcpi_insn/rs1/rs2=0, counter=0 and wait_seen=0.
REQ-029 Reset asserted during ISSUE SHALL drop pcpi_valid asynchronously, and no completion record SHALL be produced for the aborted instruction.

Configuration
REQ-030 With macro PCPI_ISSUE_TIMEOUT_EN defined, the module SHALL implement the timeout of REQ-019 to REQ-022.
REQ-031 Without PCPI_ISSUE_TIMEOUT_EN, the module SHALL omit the counter and wait_seen, remain in ISSUE until pcpi_ready, and tie done_illinsn to 0.

Verification
REQ-032 Issue insn=0x02C58533, rs1=7, rs2=6, with responder ready after 3 cycles, wr=1, rd=42 -> pcpi_valid high 3 cycles; done_valid=1, done_wr=1, done_rd=42, done_illinsn=0.
REQ-033 Issue with no responder and the macro defined -> pcpi_valid high exactly 16 cycles, then done_illinsn=1, done_rd=0; without the macro, pcpi_valid stays high for 100+ cycles with no completion.
REQ-034 Responder asserts pcpi_wait in cycle 2 and ready in cycle 40 with rd=0xDEADBEEF -> no illinsn, done_rd=0xDEADBEEF.
REQ-035 pcpi_ready in the 16th cycle (timeout cycle) with wr=0, rd=5 -> done_illinsn=0, done_wr=0, done_rd=0.
REQ-036 Hold done_ack low 10 cycles, with issue_valid=1 and pcpi_ready pulses meanwhile -> record unchanged and issue_ready=0 throughout; ack -> IDLE next cycle.
REQ-037 Assert reset in ISSUE cycle 2 -> pcpi_valid=0 immediately; after release, issue_ready=1 and done_valid=0.
